// File: rtl/pes_seq_div.sv
// Restoring divider, one quotient bit per clock MSB first; valid WIDTH clocks after load (1 on b==0).
// No backpressure: a new load always aborts and restarts; the result is held until the next completion.
module pes_seq_div #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_quo,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_valid,
   output logic             o_busy,
   output logic             o_dbz
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_p;
   logic [CW-1:0]    r_cnt;

   logic [WIDTH:0]   w_t;
   logic             w_ge;
   logic [WIDTH-1:0] w_p_next;
   logic [WIDTH-1:0] w_a_next;

   // The partial remainder stays below B after every step, so it fits in WIDTH bits;
   // only the trial value needs the extra bit.
   assign w_t      = {r_p, r_a[WIDTH-1]};
   assign w_ge     = (w_t >= {1'b0, r_b});
   assign w_p_next = w_ge ? WIDTH'(w_t - {1'b0, r_b}) : w_t[WIDTH-1:0];
   assign w_a_next = {r_a[WIDTH-2:0], w_ge};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_p     <= '0;
         r_cnt   <= '0;
         o_quo   <= '0;
         o_rem   <= '0;
         o_valid <= 1'b0;
         o_busy  <= 1'b0;
         o_dbz   <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (i_load) begin
            if (i_b == '0) begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               o_quo   <= '1;
               o_rem   <= i_a;
               o_dbz   <= 1'b1;
               o_valid <= 1'b1;
               o_busy  <= 1'b0;
            end else begin
               r_state <= S_RUN;
               r_a     <= i_a;
               r_b     <= i_b;
               r_p     <= '0;
               r_cnt   <= CW'(WIDTH);
               o_dbz   <= 1'b0;
               o_busy  <= 1'b1;
            end
         end else begin
            case (r_state)
               S_RUN: begin
                  r_a   <= w_a_next;
                  r_p   <= w_p_next;
                  r_cnt <= r_cnt - CW'(1);
                  if (r_cnt == CW'(1)) begin
                     r_state <= S_IDLE;
                     o_quo   <= w_a_next;
                     o_rem   <= w_p_next;
                     o_busy  <= 1'b0;
                     o_valid <= 1'b1;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
